// File: rtl/arbiter_grant_mux_pkg.sv
// Shared types and helpers for the arbiter grant mux: FSM states, beat layout, one-hot test.
package arbiter_grant_mux_pkg;

    localparam int unsigned GM_DATA_WIDTH   = 64;
    localparam int unsigned GM_SELECT_WIDTH = 2;

    typedef enum logic [1:0] {
        ARB,
        LOCK,
        GUARD
    } grant_mux_state_t;

    // Beat layout for the default configuration; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic [GM_DATA_WIDTH-1:0]   data;
        logic                       last;
        logic [GM_SELECT_WIDTH-1:0] id;
    } grant_mux_beat_t;

    function automatic logic onehot_check(input logic [31:0] vec);
        return (vec != '0) && ((vec & (vec - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/arbiter_grant_mux_skid_buffer.sv
// Two-entry skid buffer with registered head outputs and a registered not-full flag.
module grant_mux_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             not_full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             head_valid, tail_valid;
    logic             head_valid_next, tail_valid_next;
    logic [WIDTH-1:0] head, tail, head_next, tail_next;
    logic             pop;

    assign pop       = head_valid & out_ready;
    assign out_valid = head_valid;
    assign out_data  = head;

    always_comb begin
        head_valid_next = head_valid;
        tail_valid_next = tail_valid;
        head_next       = head;
        tail_next       = tail;
        if (pop) begin
            if (tail_valid) begin
                head_next       = tail;
                tail_valid_next = 1'b0;
            end else begin
                head_valid_next = 1'b0;
            end
        end
        if (push) begin
            if (!head_valid_next) begin
                head_next       = push_data;
                head_valid_next = 1'b1;
            end else begin
                tail_next       = push_data;
                tail_valid_next = 1'b1;
            end
        end
    end

    // not_full looks at the post-update occupancy so the upstream ready never depends on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            tail_valid <= 1'b0;
            head       <= '0;
            tail       <= '0;
            not_full   <= 1'b1;
        end else begin
            head_valid <= head_valid_next;
            tail_valid <= tail_valid_next;
            head       <= head_next;
            tail       <= tail_next;
            not_full   <= !tail_valid_next;
        end
    end

endmodule

// File: rtl/arbiter_grant_mux.sv
// Locks onto the arbiter-granted port for one packet (or MAX_BEATS beats) and forwards it
// through a skid buffer to a shared output tagged with the source port id.
module arbiter_grant_mux
    import arbiter_grant_mux_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned SELECT_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned MAX_BEATS      = 16,
    parameter int unsigned BEAT_CNT_WIDTH = 5
) (
    input  logic                            ap_clk,
    input  logic                            areset_n,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_last,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [NUM_PORTS-1:0]            arb_req,
    output logic                            arb_enable,
    input  logic [NUM_PORTS-1:0]            arb_grant,
    input  logic [SELECT_WIDTH-1:0]         arb_select,
    input  logic                            arb_valid,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    output logic [SELECT_WIDTH-1:0]         out_id,
    input  logic                            out_ready,
    output logic                            lock_active
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic                    last;
        logic [SELECT_WIDTH-1:0] id;
    } beat_t;

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_CNT = BEAT_CNT_WIDTH'(MAX_BEATS - 1);

    grant_mux_state_t          state, state_next;
    logic [SELECT_WIDTH-1:0]   lock_id, lock_id_next;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt, beat_cnt_next;
    logic                      skid_not_full;
    logic                      push;
    logic                      capture;
    beat_t                     push_beat, head_beat;

    assign capture = arb_valid && onehot_check(32'(arb_grant)) && ((arb_grant & in_valid) != '0);

    always_comb begin
        state_next     = state;
        lock_id_next   = lock_id;
        beat_cnt_next  = beat_cnt;
        arb_req        = '0;
        in_ready       = '0;
        push           = 1'b0;
        push_beat.data = in_data[lock_id*DATA_WIDTH +: DATA_WIDTH];
        push_beat.last = in_last[lock_id] | (beat_cnt == LAST_CNT);
        push_beat.id   = lock_id;
        unique case (state)
            ARB: begin
                arb_req = in_valid;
                if (capture) begin
                    lock_id_next  = arb_select;
                    beat_cnt_next = '0;
                    state_next    = LOCK;
                end
            end
            LOCK: begin
                in_ready[lock_id] = skid_not_full;
                if (in_valid[lock_id] && skid_not_full) begin
                    push          = 1'b1;
                    beat_cnt_next = beat_cnt + 1'b1;
                    if (push_beat.last) state_next = GUARD;
                end
            end
            GUARD: begin
                arb_req    = in_valid;
                state_next = ARB;
            end
            default: state_next = ARB;
        endcase
    end

    // arb_enable is registered from the next state: same cycle-by-cycle value as a decode of
    // state, but held low while reset is asserted.
    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= ARB;
            lock_id    <= '0;
            beat_cnt   <= '0;
            arb_enable <= 1'b0;
        end else begin
            state      <= state_next;
            lock_id    <= lock_id_next;
            beat_cnt   <= beat_cnt_next;
            arb_enable <= (state_next != LOCK);
        end
    end

    assign lock_active = (state == LOCK);

    grant_mux_skid_buffer #(
        .WIDTH($bits(beat_t))
    ) u_skid (
        .clk      (ap_clk),
        .rst_n    (areset_n),
        .push     (push),
        .push_data(push_beat),
        .not_full (skid_not_full),
        .out_valid(out_valid),
        .out_data (head_beat),
        .out_ready(out_ready)
    );

    assign out_data = head_beat.data;
    assign out_last = head_beat.last;
    assign out_id   = head_beat.id;

endmodule

// File: tb/tb_arbiter_grant_mux.sv
// Directed bench for arbiter_grant_mux with a round-robin arbiter model and a beat scoreboard.
module tb_arbiter_grant_mux;

    localparam int unsigned NP = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned MB = 4;

    logic              ap_clk   = 1'b0;
    logic              areset_n = 1'b0;
    logic [NP-1:0]     in_valid = '0;
    logic [NP-1:0]     in_last  = '0;
    logic [NP*DW-1:0]  in_data  = '0;
    logic [NP-1:0]     in_ready, arb_req, arb_grant;
    logic              arb_enable, arb_valid;
    logic [SW-1:0]     arb_select;
    logic              out_valid, out_last, lock_active;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_id;

    always #5 ap_clk = ~ap_clk;

    arbiter_grant_mux #(
        .NUM_PORTS     (NP),
        .SELECT_WIDTH  (SW),
        .DATA_WIDTH    (DW),
        .MAX_BEATS     (MB),
        .BEAT_CNT_WIDTH(3)
    ) dut (
        .ap_clk     (ap_clk),
        .areset_n   (areset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .arb_req    (arb_req),
        .arb_enable (arb_enable),
        .arb_grant  (arb_grant),
        .arb_select (arb_select),
        .arb_valid  (arb_valid),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .lock_active(lock_active)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [SW-1:0] id;
    } exp_t;

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    exp_t          exp_q[$];
    int            hs_q[$];
    logic [DW:0]   src_q[NP][$];
    int            acc_cnt[NP];
    int            split_cnt[NP];
    logic [NP-1:0] acc_pend = '0;

    // Arbiter model: registered grant, re-evaluated when enable rises or nothing is granted.
    logic          manual = 1'b0;
    logic [NP-1:0] man_grant = '0, mdl_grant;
    logic [SW-1:0] man_sel = '0, mdl_sel;
    logic          man_valid = 1'b0, mdl_valid, en_prev;
    int            ptr;

    assign arb_grant  = manual ? man_grant : mdl_grant;
    assign arb_select = manual ? man_sel   : mdl_sel;
    assign arb_valid  = manual ? man_valid : mdl_valid;

    always @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            mdl_grant <= '0;
            mdl_sel   <= '0;
            mdl_valid <= 1'b0;
            en_prev   <= 1'b0;
            ptr       <= NP - 1;
        end else begin
            en_prev <= arb_enable;
            if (arb_enable && (!en_prev || mdl_grant == '0)) begin
                int pick;
                pick = -1;
                for (int k = 1; k <= NP; k++)
                    if (pick < 0 && arb_req[(ptr + k) % NP]) pick = (ptr + k) % NP;
                if (pick >= 0) begin
                    mdl_grant <= NP'(1) << pick;
                    mdl_sel   <= SW'(pick);
                    mdl_valid <= 1'b1;
                    ptr       <= pick;
                end else begin
                    mdl_grant <= '0;
                    mdl_valid <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Source drivers: pop beats accepted at the edge, then present the next queued beat.
    always @(posedge ap_clk) begin
        logic [NP-1:0] acc;
        logic [DW:0]   f;
        acc = acc_pend & {NP{areset_n}};
        #2;
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && src_q[p].size() > 0) begin
                void'(src_q[p].pop_front());
                acc_cnt[p]++;
            end
            if (src_q[p].size() > 0) begin
                f = src_q[p][0];
                in_valid[p]         = 1'b1;
                in_last[p]          = f[DW];
                in_data[p*DW +: DW] = f[DW-1:0];
            end else begin
                in_valid[p]         = 1'b0;
                in_last[p]          = 1'b0;
                in_data[p*DW +: DW] = '0;
            end
        end
    end

    always @(posedge ap_clk) cyc++;

    always @(negedge ap_clk) begin
        exp_t e;
        acc_pend = in_valid & in_ready;
        if (areset_n && out_valid && out_ready) begin
            hs_q.push_back(cyc);
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_last", 64'(out_last), 64'(e.last));
                chk("out_id", 64'(out_id), 64'(e.id));
                if (out_last) begin
                    chk("unlocked_at_last", 64'(lock_active), 64'd0);
                    chk("ready_low_at_last", 64'(in_ready), 64'd0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_bench();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            acc_cnt[p]   = 0;
            split_cnt[p] = 0;
        end
        exp_q.delete();
        hs_q.delete();
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        clear_bench();
        tick(3);
        areset_n = 1'b1;
        tick(2);
    endtask

    task automatic send(input int p, input int n, input logic [DW-1:0] base);
        for (int b = 0; b < n; b++) begin
            exp_t e;
            logic l;
            l = (b == n - 1);
            src_q[p].push_back({l, base + DW'(b)});
            e.data = base + DW'(b);
            e.id   = SW'(p);
            e.last = l || (split_cnt[p] == MB - 1);
            split_cnt[p] = e.last ? 0 : split_cnt[p] + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_lock(input string tag, input int budget);
        int n;
        n = 0;
        while (!lock_active && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(lock_active), 64'd1);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_lock_active", 64'(lock_active), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_arb_enable", 64'(arb_enable), 64'd0);
        tick(1);
        areset_n = 1'b1;
        tick(2);

        // Single requestor, 3-beat packet on port 2.
        send(2, 3, 64'hA0);
        wait_drain("t1_drain", 40);
        chk("t1_hs_count", 64'(hs_q.size()), 64'd3);
        if (hs_q.size() == 3) begin
            chk("t1_gap01", 64'(hs_q[1] - hs_q[0]), 64'd1);
            chk("t1_gap12", 64'(hs_q[2] - hs_q[1]), 64'd1);
        end
        chk("t1_lock_released", 64'(lock_active), 64'd0);
        chk("t1_ready_idle", 64'(in_ready), 64'd0);

        // All ports with two 2-beat packets: strict rotation 0,1,2,3,0,1,2,3.
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++)
                send(p, 2, 64'h1000 * (p + 1) + 64'h10 * k);
        wait_drain("t2_drain", 200);

        // Backpressure on port 1: skid fills with exactly two beats.
        do_reset();
        out_ready = 1'b0;
        send(1, 4, 64'hB0);
        wait_lock("t3_lock", 20);
        tick(5);
        chk("t3_accepted", 64'(acc_cnt[1]), 64'd2);
        chk("t3_ready_low", 64'(in_ready[1]), 64'd0);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        chk("t3_hold_data", out_data, 64'hB0);
        tick(1);
        chk("t3_hold_data2", out_data, 64'hB0);
        out_ready = 1'b1;
        wait_drain("t3_drain", 40);
        chk("t3_total_accepted", 64'(acc_cnt[1]), 64'd4);

        // 6-beat packet on port 0 with MAX_BEATS=4: forced release after beat 4.
        do_reset();
        send(0, 6, 64'hC0);
        wait_drain("t4_drain", 60);
        chk("t4_hs_count", 64'(hs_q.size()), 64'd6);
        if (hs_q.size() == 6)
            chk("t4_regrant_gap", 64'(hs_q[4] - hs_q[3] >= 3), 64'd1);

        // Multi-hot grant is ignored; a following one-hot grant locks port 1.
        do_reset();
        manual    = 1'b1;
        man_grant = 4'b0011;
        man_sel   = 2'd0;
        man_valid = 1'b1;
        send(1, 2, 64'hD0);
        tick(4);
        chk("t5_no_lock", 64'(lock_active), 64'd0);
        chk("t5_no_ready", 64'(in_ready), 64'd0);
        chk("t5_no_accept", 64'(acc_cnt[1]), 64'd0);
        man_grant = 4'b0010;
        man_sel   = 2'd1;
        tick(1);
        chk("t5_locked", 64'(lock_active), 64'd1);
        man_grant = '0;
        man_valid = 1'b0;
        wait_drain("t5_drain", 40);
        manual = 1'b0;

        // Asynchronous reset with two beats held in the skid.
        do_reset();
        out_ready = 1'b0;
        send(2, 4, 64'hE0);
        wait_lock("t6_lock", 20);
        tick(4);
        chk("t6_held", 64'(acc_cnt[2]), 64'd2);
        chk("t6_out_valid", 64'(out_valid), 64'd1);
        #2;
        areset_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_lock", 64'(lock_active), 64'd0);
        chk("t6_rst_ready", 64'(in_ready), 64'd0);
        clear_bench();
        tick(2);
        areset_n = 1'b1;
        tick(2);
        out_ready = 1'b1;
        send(3, 2, 64'hF0);
        wait_drain("t6_after_drain", 40);
        chk("t6_after_unlock", 64'(lock_active), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
